// File: rtl/hxd32_mem_arb.sv
// Single-port SRAM arbiter between hxd32 instruction fetch (I) and load/store (D) paths.
// Define HXD32_MEM_ARB_RR_EN for round-robin contention instead of D priority with starve escape.
module hxd32_mem_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ireq_valid_i,
  input  logic [XLEN-1:0] ireq_addr_i,
  output logic            ireq_ready_o,
  output logic            irsp_valid_o,
  output logic [XLEN-1:0] irsp_data_o,
  input  logic            dreq_valid_i,
  input  logic [3:0]      dreq_byte_en_i,
  input  logic [XLEN-1:0] dreq_addr_i,
  input  logic [XLEN-1:0] dreq_wr_data_i,
  output logic            dreq_ready_o,
  output logic            drsp_valid_o,
  output logic [XLEN-1:0] drsp_data_o,
  output logic            mem_en_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_wr_byte_en_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

  // Requests are masked while reset is asserted so nothing is granted or strobed.
  logic i_vld, d_vld, i_win, d_win;
  assign i_vld = ireq_valid_i & rst_n_i;
  assign d_vld = dreq_valid_i & rst_n_i;

`ifdef HXD32_MEM_ARB_RR_EN
  owner_e rr_last_q, rr_last_d;

  always_comb begin
    i_win     = i_vld & (~d_vld | (rr_last_q == OwnD));
    d_win     = d_vld & ~i_win;
    rr_last_d = rr_last_q;
    if (i_vld && d_vld) begin
      rr_last_d = i_win ? OwnI : OwnD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_last_q <= OwnD;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [StarveW-1:0] StarveMaxW = StarveW'(STARVE_MAX);
  localparam bit StarveEn = (STARVE_MAX != 0);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               starve_esc;

  always_comb begin
    starve_esc = StarveEn && (starve_q == StarveMaxW);
    i_win      = i_vld & (~d_vld | starve_esc);
    d_win      = d_vld & ~i_win;
    starve_d   = starve_q;
    if (!ireq_valid_i || i_win) begin
      starve_d = '0;
    end else if (starve_q != StarveMaxW) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign ireq_ready_o = i_win;
  assign dreq_ready_o = d_win;
  assign mem_en_o     = i_win | d_win;

  always_comb begin
    mem_addr_o       = '0;
    mem_wr_byte_en_o = '0;
    mem_wr_data_o    = '0;
    if (i_win) begin
      mem_addr_o = ireq_addr_i;
    end else if (d_win) begin
      mem_addr_o       = dreq_addr_i;
      mem_wr_byte_en_o = dreq_byte_en_i;
      mem_wr_data_o    = dreq_wr_data_i;
    end
  end

  // Owner tags travel alongside the SRAM read pipeline; writes push an empty slot.
  logic              push_vld;
  owner_e            push_own;
  logic [RD_LAT-1:0] tag_vld_q;
  owner_e            tag_own_q [RD_LAT];

  assign push_vld = i_win | (d_win & (dreq_byte_en_i == 4'b0000));
  assign push_own = i_win ? OwnI : OwnD;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_own_q[i] <= OwnI;
      end
    end else begin
      tag_vld_q[0] <= push_vld;
      tag_own_q[0] <= push_own;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  always_comb begin
    irsp_valid_o = tag_vld_q[RD_LAT-1] & (tag_own_q[RD_LAT-1] == OwnI);
    drsp_valid_o = tag_vld_q[RD_LAT-1] & (tag_own_q[RD_LAT-1] == OwnD);
    irsp_data_o  = irsp_valid_o ? mem_rd_data_i : '0;
    drsp_data_o  = drsp_valid_o ? mem_rd_data_i : '0;
  end

endmodule

// File: tb/tb_hxd32_mem_arb.sv
// Directed bench for hxd32_mem_arb: one instance with RD_LAT=1 and one with RD_LAT=3,
// sharing request stimulus, each with its own SRAM model.
module tb_hxd32_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        dreq_valid;
  logic [3:0]  dreq_be;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wd;

  logic        iready1, irv1, dready1, drv1, men1;
  logic [31:0] ird1, drd1, maddr1, mwd1, mrd1;
  logic [3:0]  mbe1;
  logic        iready3, irv3, dready3, drv3, men3;
  logic [31:0] ird3, drd3, maddr3, mwd3, mrd3;
  logic [3:0]  mbe3;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hxd32_mem_arb #(.XLEN(32), .RD_LAT(1), .STARVE_MAX(3)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ireq_valid_i(ireq_valid), .ireq_addr_i(ireq_addr), .ireq_ready_o(iready1),
    .irsp_valid_o(irv1), .irsp_data_o(ird1),
    .dreq_valid_i(dreq_valid), .dreq_byte_en_i(dreq_be), .dreq_addr_i(dreq_addr),
    .dreq_wr_data_i(dreq_wd), .dreq_ready_o(dready1),
    .drsp_valid_o(drv1), .drsp_data_o(drd1),
    .mem_en_o(men1), .mem_addr_o(maddr1), .mem_wr_byte_en_o(mbe1),
    .mem_wr_data_o(mwd1), .mem_rd_data_i(mrd1)
  );

  hxd32_mem_arb #(.XLEN(32), .RD_LAT(3), .STARVE_MAX(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ireq_valid_i(ireq_valid), .ireq_addr_i(ireq_addr), .ireq_ready_o(iready3),
    .irsp_valid_o(irv3), .irsp_data_o(ird3),
    .dreq_valid_i(dreq_valid), .dreq_byte_en_i(dreq_be), .dreq_addr_i(dreq_addr),
    .dreq_wr_data_i(dreq_wd), .dreq_ready_o(dready3),
    .drsp_valid_o(drv3), .drsp_data_o(drd3),
    .mem_en_o(men3), .mem_addr_o(maddr3), .mem_wr_byte_en_o(mbe3),
    .mem_wr_data_o(mwd3), .mem_rd_data_i(mrd3)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  // SRAM models: read data after RD_LAT edges, junk otherwise so ungated data shows up.
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    mrd1  <= (men1 && mbe1 == 4'b0000) ? mem_val(maddr1) : 32'hCAFE_F00D;
    p3[0] <= (men3 && mbe3 == 4'b0000) ? mem_val(maddr3) : 32'hCAFE_F00D;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrd3 = p3[2];

  logic [136:0] outs1, outs3;
  assign outs1 = {iready1, irv1, ird1, dready1, drv1, drd1, men1, maddr1, mbe1, mwd1};
  assign outs3 = {iready3, irv3, ird3, dready3, drv3, drd3, men3, maddr3, mbe3, mwd3};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // own: 0 = no response, 1 = I response, 2 = D response
  task automatic chk_rsp(input string tag, input logic iv, input logic [31:0] id,
                         input logic dv, input logic [31:0] dd,
                         input int own, input logic [31:0] data);
    chk({tag, ".irsp_valid"}, 160'(iv), 160'(own == 1));
    chk({tag, ".irsp_data"}, 160'(id), 160'((own == 1) ? data : 32'h0));
    chk({tag, ".drsp_valid"}, 160'(dv), 160'(own == 2));
    chk({tag, ".drsp_data"}, 160'(dd), 160'((own == 2) ? data : 32'h0));
  endtask

  task automatic set_idle();
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    dreq_valid = 1'b0;
    dreq_be    = '0;
    dreq_addr  = '0;
    dreq_wd    = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] igrant;

  initial begin
    // Reset with both requests pending: everything must stay quiet.
    rst_n      = 1'b0;
    ireq_valid = 1'b1;
    ireq_addr  = 32'h100;
    dreq_valid = 1'b1;
    dreq_be    = 4'hF;
    dreq_addr  = 32'h200;
    dreq_wd    = 32'h11;
    #1;
    chk("rst.outs1", 160'(outs1), '0);
    chk("rst.outs3", 160'(outs3), '0);
    @(negedge clk);
    #1;
    chk("rst_edge.outs1", 160'(outs1), '0);
    chk("rst_edge.outs3", 160'(outs3), '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    // Test 1: lone I read, RD_LAT=1.
    @(negedge clk);
    ireq_valid = 1'b1;
    ireq_addr  = 32'h100;
    #1;
    chk("t1.iready", 160'(iready1), 160'(1'b1));
    chk("t1.dready", 160'(dready1), 160'(1'b0));
    chk("t1.mem_en", 160'(men1), 160'(1'b1));
    chk("t1.mem_addr", 160'(maddr1), 160'(32'h100));
    chk("t1.mem_be", 160'(mbe1), 160'(4'h0));
    chk("t1.mem_wd", 160'(mwd1), 160'(32'h0));
    @(negedge clk);
    set_idle();
    #1;
    chk_rsp("t1.rsp", irv1, ird1, drv1, drd1, 1, 32'hDEAD_BEEF);
    chk("t1.idle_en", 160'(men1), 160'(1'b0));
    @(negedge clk);
    #1;
    chk_rsp("t1.after", irv1, ird1, drv1, drd1, 0, 32'h0);
    idle(4);

    // Test 2: contention for 8 cycles; starvation escape (or round-robin) pattern.
`ifdef HXD32_MEM_ARB_RR_EN
    igrant = 8'b0101_0101;
`else
    igrant = 8'b1000_1000;
`endif
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        ireq_valid = 1'b1;
        ireq_addr  = 32'h300;
        dreq_valid = 1'b1;
        dreq_be    = 4'h0;
        dreq_addr  = 32'h400;
        dreq_wd    = 32'h55AA;
      end else begin
        set_idle();
      end
      #1;
      if (k < 8) begin
        chk($sformatf("t2.iready[%0d]", k), 160'(iready1), 160'(igrant[k]));
        chk($sformatf("t2.dready[%0d]", k), 160'(dready1), 160'(!igrant[k]));
        chk($sformatf("t2.addr[%0d]", k), 160'(maddr1),
            160'(igrant[k] ? 32'h300 : 32'h400));
        chk($sformatf("t2.wd[%0d]", k), 160'(mwd1), 160'(igrant[k] ? 32'h0 : 32'h55AA));
      end
      if (k > 0) begin
        chk_rsp($sformatf("t2.rsp[%0d]", k), irv1, ird1, drv1, drd1,
                igrant[k-1] ? 1 : 2, igrant[k-1] ? mem_val(32'h300) : mem_val(32'h400));
      end
    end
    idle(4);

    // Test 3: D write produces no response.
    @(negedge clk);
    dreq_valid = 1'b1;
    dreq_be    = 4'b0011;
    dreq_addr  = 32'h200;
    dreq_wd    = 32'h1234_5678;
    #1;
    chk("t3.dready", 160'(dready1), 160'(1'b1));
    chk("t3.iready", 160'(iready1), 160'(1'b0));
    chk("t3.mem_en", 160'(men1), 160'(1'b1));
    chk("t3.mem_be", 160'(mbe1), 160'(4'b0011));
    chk("t3.mem_addr", 160'(maddr1), 160'(32'h200));
    chk("t3.mem_wd", 160'(mwd1), 160'(32'h1234_5678));
    chk("t3.mem_be3", 160'(mbe3), 160'(4'b0011));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      set_idle();
      #1;
      chk_rsp($sformatf("t3.rsp1[%0d]", k), irv1, ird1, drv1, drd1, 0, 32'h0);
      chk_rsp($sformatf("t3.rsp3[%0d]", k), irv3, ird3, drv3, drd3, 0, 32'h0);
    end

    // Test 4: RD_LAT=3, alternating I/D reads, responses on cycles 3..6.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      set_idle();
      if (c < 4) begin
        if (c % 2 == 0) begin
          ireq_valid = 1'b1;
          ireq_addr  = 32'(16 * (c + 1));
        end else begin
          dreq_valid = 1'b1;
          dreq_addr  = 32'(16 * (c + 1));
        end
      end
      #1;
      if (c < 4) begin
        chk($sformatf("t4.iready[%0d]", c), 160'(iready3), 160'(c % 2 == 0));
        chk($sformatf("t4.dready[%0d]", c), 160'(dready3), 160'(c % 2 == 1));
      end
      if (c >= 3 && c <= 6) begin
        chk_rsp($sformatf("t4.rsp[%0d]", c), irv3, ird3, drv3, drd3,
                ((c - 3) % 2 == 0) ? 1 : 2, mem_val(32'(16 * (c - 2))));
      end else begin
        chk_rsp($sformatf("t4.rsp[%0d]", c), irv3, ird3, drv3, drd3, 0, 32'h0);
      end
    end
    idle(1);

    // Test 5: reset between acceptance and data return flushes the pending read.
    @(negedge clk);
    ireq_valid = 1'b1;
    ireq_addr  = 32'h500;
    #1;
    chk("t5.iready3", 160'(iready3), 160'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5.rst.outs1", 160'(outs1), '0);
    chk("t5.rst.outs3", 160'(outs3), '0);
    @(negedge clk);
    #1;
    chk("t5.rst2.outs3", 160'(outs3), '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_rsp($sformatf("t5.rsp3[%0d]", k), irv3, ird3, drv3, drd3, 0, 32'h0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
